run_sequence_detector: RTL
==========================

# run_sequence_detector

Parametrised run-ordered symbol sequence recogniser, the next generation of the `counting` symbol-stream checker. It samples one small symbol per valid cycle. It recognises streams of the form 1+ 2+ … N+, where each run is at least MIN_RUN long. It reports recognition as a level or as a pulse on `ans` and keeps a saturating match count. It sits directly on a symbol stream next to the existing stimulus sources and adds a valid qualifier, a sync clear and a run-length requirement.

## Interface
- SYM_W, 2, symbol width in bits.
- NUM_STAGES, 3, number of ordered symbols (1..NUM_STAGES); legal range 2..2^SYM_W-1.
- MIN_RUN, 1, minimum run length per symbol; legal range ≥1.
- CNT_W, 8, width of `match_cnt`.
- Illegal parameter values are an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  `num` is sampled this cycle.
- num  in  SYM_W  input symbol.
- pulse_mode  in  1  0 = level output, 1 = single-cycle pulse per match.
- clr  in  1  synchronous clear.
- ans  out  1  registered match indication.
- match_cnt  out  CNT_W  number of match events, saturating at all-ones.
- stage  out  clog2(NUM_STAGES+1)  current stage; 0 = idle.

## Operation
- State:
  - `stage` (0..NUM_STAGES).
  - `run` counter saturating at MIN_RUN (width clog2(MIN_RUN+1), min 1).
- Per sample (`in_valid`=1, `clr`=0), with symbol x, in priority order:
  - x==1: if stage==1, run=sat(run+1); else stage=1, run=1. A 1 restarts from any stage.
  - x==stage and stage≥2: run=sat(run+1).
  - x==stage+1, stage≥1, run==MIN_RUN: stage=x, run=1.
  - Otherwise (x==0, x>NUM_STAGES, skipped symbol, short run, backward step): stage=0, run=0.
- Matched condition: next stage==NUM_STAGES and next run==MIN_RUN.
- Match event: matched condition is true and the current state was not already (NUM_STAGES, MIN_RUN).
- `ans` next value:
  - pulse_mode=0: equals the matched condition.
  - pulse_mode=1: equals the match event.
- `match_cnt` increments on every match event, independent of `pulse_mode`; it holds at 2^CNT_W-1.
- `in_valid`=0: stage and run hold; `match_cnt` holds.
  - pulse_mode=0: `ans` holds.
  - pulse_mode=1: `ans` goes 0.
- `clr`=1 overrides `in_valid`: stage=0, run=0, ans=0, match_cnt=0 at the next edge.
- Changing `pulse_mode` affects only the next update; there is no retroactive change.

## Timing
- Reset (rst_n low, asynchronous): stage=0, run=0, ans=0, match_cnt=0 immediately and while held. The first sample is taken on the first rising edge after release.
- Latency: symbol sampled at edge k; `ans`, `stage` and `match_cnt` reflect it after edge k (one-cycle registered). There is no combinational path from inputs to outputs.
- Throughput: one symbol per cycle, no stalls, no backpressure.
- Reset asserted mid-run discards all progress; the next stream must restart with symbol 1.
- With MIN_RUN=1, entering stage NUM_STAGES is itself a match event.
- Each repeated final symbol keeps the matched condition true without generating a new event.

## Test plan
- Defaults, pulse_mode=0, in_valid=1, stream 1,1,2,3,3,1,2,1,1,1,2,2,3,3,3,1 -> ans per cycle 0,0,0,1,1,0,0,0,0,0,0,0,1,1,1,0; match_cnt ends at 2.
- Same stream with pulse_mode=1 -> ans 0,0,0,1,0,0,0,0,0,0,0,0,1,0,0,0; match_cnt=2.
- MIN_RUN=2:
  - 1,2,2,3,3 -> stage returns to 0 on the first 2; ans never 1.
  - 1,1,2,2,3,3 -> ans=1 only after the final 3; match_cnt=1.
- Gaps and invalid symbols:
  - 1,2 then in_valid=0 for 3 cycles, then 3 -> stage holds at 2 during the gap; ans=1 after 3.
  - 1,3 -> stage=0.
  - 1,2,0 -> stage=0, ans=0.
- Control and reset:
  - clr asserted with in_valid=1 during the final run -> all outputs 0 next cycle.
  - rst_n pulsed low mid-clock -> outputs 0 without waiting for an edge.
- CNT_W=2, pulse_mode=1, five complete 1,2,3 sequences -> match_cnt 1,2,3,3,3; ans pulses five times.

Source files
------------

// File: rtl/run_sequence_detector.sv
// -----------------------------------------------------------------------------
// run_sequence_detector
//
// Recognises run-ordered symbol streams of the form 1+ 2+ ... N+ (N =
// NUM_STAGES). Every run must be at least MIN_RUN samples long before the
// stream may advance to the next symbol. One symbol is sampled per cycle
// while in_valid is high. A match is reported on ans, either as a level that
// stays high while the final run continues or as a single-cycle pulse. The
// number of match events is kept in a saturating counter.
//
// Ports
//   clk         in   rising-edge clock for all state
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   num is sampled this cycle
//   num         in   SYM_W  input symbol
//   pulse_mode  in   0 = level ans, 1 = single-cycle pulse per match event
//   clr         in   synchronous clear of all state; overrides in_valid
//   ans         out  registered match indication
//   match_cnt   out  CNT_W  match events, saturating at all-ones
//   stage       out  current stage, 0 = idle
// -----------------------------------------------------------------------------
module run_sequence_detector #(
    parameter int  SYM_W      = 2,
    parameter int  NUM_STAGES = 3,
    parameter int  MIN_RUN    = 1,
    parameter int  CNT_W      = 8,
    localparam int STAGE_W    = $clog2(NUM_STAGES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [SYM_W-1:0]   num,
    input  logic               pulse_mode,
    input  logic               clr,
    output logic               ans,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [STAGE_W-1:0] stage
);

    // Run counter only has to count up to MIN_RUN; keep at least one bit.
    localparam int RUN_W_RAW = $clog2(MIN_RUN + 1);
    localparam int RUN_W     = (RUN_W_RAW < 1) ? 1 : RUN_W_RAW;

    // Common width for comparing the symbol against stage and stage+1.
    // The extra bit keeps stage+1 from wrapping at the top stage.
    localparam int CMP_W = ((SYM_W > STAGE_W) ? SYM_W : STAGE_W) + 1;

    localparam logic [STAGE_W-1:0] STAGE_IDLE  = '0;
    localparam logic [STAGE_W-1:0] STAGE_FIRST = STAGE_W'(1);
    localparam logic [STAGE_W-1:0] STAGE_LAST  = STAGE_W'(NUM_STAGES);
    localparam logic [RUN_W-1:0]   RUN_ZERO    = '0;
    localparam logic [RUN_W-1:0]   RUN_ONE     = RUN_W'(1);
    localparam logic [RUN_W-1:0]   RUN_FULL    = RUN_W'(MIN_RUN);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    // -------------------------------------------------------------------------
    // Parameter legality, rejected at elaboration
    // -------------------------------------------------------------------------
    generate
        if (SYM_W < 1) begin : g_bad_sym_w
            $error("run_sequence_detector: SYM_W must be at least 1");
        end
        if (NUM_STAGES < 2 || NUM_STAGES > ((1 << SYM_W) - 1)) begin : g_bad_stages
            $error("run_sequence_detector: NUM_STAGES must be in 2..2^SYM_W-1");
        end
        if (MIN_RUN < 1) begin : g_bad_min_run
            $error("run_sequence_detector: MIN_RUN must be at least 1");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("run_sequence_detector: CNT_W must be at least 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [RUN_W-1:0]   run_q,   run_d;
    logic               ans_q,   ans_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // Helpers shared by the next-state and output logic
    logic [CMP_W-1:0] sym_ext;
    logic [CMP_W-1:0] stage_ext;
    logic             run_full;
    logic [RUN_W-1:0] run_inc;
    logic             matched;
    logic             at_match_q;
    logic             match_evt;

    assign sym_ext   = CMP_W'(num);
    assign stage_ext = CMP_W'(stage_q);
    assign run_full  = (run_q == RUN_FULL);
    assign run_inc   = run_full ? run_q : run_q + RUN_ONE;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= STAGE_IDLE;
            run_q   <= RUN_ZERO;
            ans_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            run_q   <= run_d;
            ans_q   <= ans_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: stage / run transitions in priority order
    // -------------------------------------------------------------------------
    always_comb begin
        stage_d = stage_q;
        run_d   = run_q;
        if (clr) begin
            stage_d = STAGE_IDLE;
            run_d   = RUN_ZERO;
        end else if (in_valid) begin
            if (sym_ext == CMP_W'(1)) begin
                // A 1 always (re)starts the sequence, or extends the first run.
                if (stage_q == STAGE_FIRST) begin
                    run_d = run_inc;
                end else begin
                    stage_d = STAGE_FIRST;
                    run_d   = RUN_ONE;
                end
            end else if (sym_ext == stage_ext && stage_q >= STAGE_W'(2)) begin
                run_d = run_inc;
            end else if (sym_ext == stage_ext + CMP_W'(1) &&
                         stage_q != STAGE_IDLE && stage_q != STAGE_LAST &&
                         run_full) begin
                // Advance only after the current run reached MIN_RUN.
                stage_d = stage_q + STAGE_FIRST;
                run_d   = RUN_ONE;
            end else begin
                // 0, out-of-range symbol, skipped symbol, short run or
                // backward step all abandon the sequence.
                stage_d = STAGE_IDLE;
                run_d   = RUN_ZERO;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: ans and match counter next values
    // -------------------------------------------------------------------------
    assign matched    = (stage_d == STAGE_LAST) && (run_d == RUN_FULL);
    // Already sitting in the matched state: further final symbols keep the
    // condition true without counting as a new event.
    assign at_match_q = (stage_q == STAGE_LAST) && run_full;
    assign match_evt  = matched && !at_match_q;

    always_comb begin
        ans_d = ans_q;
        cnt_d = cnt_q;
        if (clr) begin
            ans_d = 1'b0;
            cnt_d = '0;
        end else if (in_valid) begin
            ans_d = pulse_mode ? match_evt : matched;
            if (match_evt && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pulse_mode) begin
            // A pulse never stretches across an idle cycle.
            ans_d = 1'b0;
        end
    end

    assign ans       = ans_q;
    assign match_cnt = cnt_q;
    assign stage     = stage_q;

endmodule
